// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter that lends one shared ALU to two requesters and returns a tagged response.
// Latency: request accepted at edge N, ALU result captured at edge N+1, rsp_valid high from the cycle after N+1.
// Backpressure: new requests are held off (ready=0) until the response is taken; the response holds while rsp_ready=0.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // One requester's operation bundle, muxed as a unit at grant time.
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_req_t;

  // The ALU has no implementation for this code; the block answers it itself.
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t   state;
  logic     last_grant;
  logic     any_req;
  logic     grant_id;
  logic     accept;
  alu_req_t sel_req;

  // Pick the winner: alternate on contention, otherwise take whoever is asking.
  always_comb begin
    any_req  = req0_valid | req1_valid;
    grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept   = (state == IDLE) && any_req && !rst;
    sel_req  = grant_id ? '{op: req1_op, a: req1_a, b: req1_b}
                        : '{op: req0_op, a: req0_a, b: req0_b};
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
  end

  // Transaction sequencer: latch the granted operation, capture the ALU answer, hold it until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= EXEC;
            last_grant <= grant_id;
            rsp_id     <= grant_id;
            alu_op     <= sel_req.op;
            alu_a      <= sel_req.a;
            alu_b      <= sel_req.b;
          end
        end
        EXEC: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          if (alu_op == OP_ILLEGAL) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_neg    <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_neg    <= alu_neg;
            rsp_err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: randomized and directed bench for alu_arbiter with a transaction-level reference model.
// Latency: expects grant in the request cycle, EXEC next, response two cycles after acceptance.
// Backpressure: holds rsp_ready low for chosen cycle counts and checks the response stays put.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         tv[2];
  logic [2:0]   top[2];
  logic [W-1:0] ta[2];
  logic [W-1:0] tbv[2];
  logic         req0_ready, req1_ready;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero, alu_neg;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_err, rsp_ready;
  logic [W-1:0] rsp_result;

  int n_checks = 0;
  int n_fail   = 0;
  int last_id  = 1;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(tv[0]), .req0_op(top[0]), .req0_a(ta[0]), .req0_b(tbv[0]), .req0_ready(req0_ready),
    .req1_valid(tv[1]), .req1_op(top[1]), .req1_a(ta[1]), .req1_b(tbv[1]), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  // Shared ALU environment; code 111 returns junk so the block's substitution is visible.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return W'($signed(a) < $signed(b));
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_op, alu_a, alu_b);
    alu_zero   = (op_is_ill(alu_op)) ? 1'b0 : (alu_result == '0);
    alu_neg    = (op_is_ill(alu_op)) ? 1'b1 : alu_result[W-1];
  end

  function automatic logic op_is_ill(input logic [2:0] op);
    return op == 3'b111;
  endfunction

  // Reference arithmetic on signed integers.
  function automatic logic [W-1:0] ref_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000:  return W'(sa + sb);
      3'b001:  return W'(sa - sb);
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return W'(64'(a) * (64'd1 << b[4:0]));
      3'b110:  return (sa < sb) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    tv[i]  = 1'b1;
    top[i] = op;
    ta[i]  = a;
    tbv[i] = b;
  endtask

  task automatic new_req(input int i);
    logic [W-1:0] a;
    a = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
    set_req(i, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : W'($urandom));
  endtask

  // One full transaction, entered just after a posedge with the DUT idle; k = cycles of response stall.
  task automatic run_txn(input int k);
    int           id;
    logic [2:0]   e_op;
    logic [W-1:0] ea, eb, er;
    logic         ez, en, ee;
    rsp_ready = (k == 0);
    @(negedge clk);
    id = (tv[0] && tv[1]) ? 1 - last_id : (tv[1] ? 1 : 0);
    check("grant_req0_ready", 64'(req0_ready), 64'(id == 0));
    check("grant_req1_ready", 64'(req1_ready), 64'(id == 1));
    check("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    e_op = top[id];
    ea   = ta[id];
    eb   = tbv[id];
    if (e_op == 3'b111) begin
      er = '0; ez = 1'b1; en = 1'b0; ee = 1'b1;
    end else begin
      er = ref_fn(e_op, ea, eb); ez = (er == '0); en = er[W-1]; ee = 1'b0;
    end
    last_id = id;
    @(posedge clk);
    #1;
    tv[id]  = 1'b0;
    top[id] = 3'($urandom);
    ta[id]  = W'($urandom);
    tbv[id] = W'($urandom);
    @(negedge clk);
    check("exec_req0_ready", 64'(req0_ready), 64'(0));
    check("exec_req1_ready", 64'(req1_ready), 64'(0));
    check("exec_rsp_valid", 64'(rsp_valid), 64'(0));
    check("exec_alu_op", 64'(alu_op), 64'(e_op));
    check("exec_alu_a", 64'(alu_a), 64'(ea));
    check("exec_alu_b", 64'(alu_b), 64'(eb));
    @(negedge clk);
    check("resp_valid", 64'(rsp_valid), 64'(1));
    check("resp_id", 64'(rsp_id), 64'(id));
    check("resp_result", 64'(rsp_result), 64'(er));
    check("resp_zero", 64'(rsp_zero), 64'(ez));
    check("resp_neg", 64'(rsp_neg), 64'(en));
    check("resp_err", 64'(rsp_err), 64'(ee));
    check("resp_req0_ready", 64'(req0_ready), 64'(0));
    check("resp_req1_ready", 64'(req1_ready), 64'(0));
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
      check("stall_rsp_result", 64'(rsp_result), 64'(er));
      check("stall_rsp_id", 64'(rsp_id), 64'(id));
      check("stall_req0_ready", 64'(req0_ready), 64'(0));
      check("stall_req1_ready", 64'(req1_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b1; top[i] = 3'b000; ta[i] = '0; tbv[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", 64'(req0_ready), 64'(0));
    check("rst_req1_ready", 64'(req1_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_result", 64'(rsp_result), 64'(0));
    check("rst_flags", 64'({rsp_zero, rsp_neg, rsp_err}), 64'(0));
    check("rst_alu_bus", 64'({alu_op, alu_a, alu_b} != 0), 64'(0));
    tv[0] = 1'b0;
    tv[1] = 1'b0;
    rst = 1'b0;
    last_id = 1;
    @(posedge clk);
    #1;

    // Contention straight out of reset: 0, then 1, then 0 again, then the held 1.
    set_req(0, 3'b000, 32'd10, 32'd20);
    set_req(1, 3'b010, 32'hF0F0, 32'h0FF0);
    run_txn(0);
    check("d_contend_first_id", 64'(rsp_id), 64'(0));
    run_txn(0);
    check("d_contend_second_id", 64'(rsp_id), 64'(1));
    set_req(0, 3'b011, 32'h1, 32'h2);
    set_req(1, 3'b100, 32'h3, 32'h5);
    run_txn(0);
    check("d_contend_third_id", 64'(rsp_id), 64'(0));
    run_txn(0);

    // Single request add.
    set_req(0, 3'b000, 32'd5, 32'd7);
    run_txn(0);
    check("d_add_result", 64'(rsp_result), 64'(12));
    check("d_add_zero", 64'(rsp_zero), 64'(0));

    // Flag cases.
    set_req(1, 3'b001, 32'd3, 32'd3);
    run_txn(0);
    check("d_sub_zero_result", 64'(rsp_result), 64'(0));
    check("d_sub_zero_flag", 64'(rsp_zero), 64'(1));
    set_req(0, 3'b001, 32'd2, 32'd5);
    run_txn(0);
    check("d_sub_neg_result", 64'(rsp_result), 64'(32'hFFFF_FFFD));
    check("d_sub_neg_flag", 64'(rsp_neg), 64'(1));

    // Four-cycle response stall with the other requester waiting.
    set_req(0, 3'b000, 32'd100, 32'd1);
    set_req(1, 3'b001, 32'd9, 32'd4);
    run_txn(4);
    run_txn(0);

    // Unsupported opcode.
    set_req(1, 3'b111, 32'd8, 32'd8);
    run_txn(0);
    check("d_ill_err", 64'(rsp_err), 64'(1));
    check("d_ill_result", 64'(rsp_result), 64'(0));
    check("d_ill_zero", 64'(rsp_zero), 64'(1));

    // Reset while EXEC: transaction vanishes, priority returns to requester 0.
    set_req(1, 3'b000, 32'd1, 32'd2);
    @(negedge clk);
    check("rx_req1_ready", 64'(req1_ready), 64'(1));
    @(posedge clk);
    #1;
    tv[1] = 1'b0;
    rst = 1'b1;
    #1;
    check("rx_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rx_alu_a", 64'(alu_a), 64'(0));
    check("rx_rsp_id", 64'(rsp_id), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    last_id = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("rx_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    set_req(0, 3'b000, 32'd40, 32'd2);
    set_req(1, 3'b000, 32'd50, 32'd3);
    run_txn(0);
    check("rx_prio_id", 64'(rsp_id), 64'(0));
    run_txn(0);

    // Randomized traffic.
    for (int t = 0; t < 120; t++) begin
      for (int i = 0; i < 2; i++)
        if (!tv[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!tv[0] && !tv[1]) new_req(int'($urandom_range(0, 1)));
      run_txn(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    @(negedge clk);
    check("final_rsp_valid", 64'(rsp_valid), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
